demux_bit_driver: RTL and testbench
===================================

Name: demux_bit_driver

Overview:
- Upstream feeder for the 1-to-4 demux (inputs `a`, `sel[1:0]`).
- Accepts parallel words tagged with a destination channel over a valid/ready handshake.
- Serialises each word LSB-first onto `a`, holding `sel` at the destination for the whole word.
- The downstream demux then steers the bit stream onto `y[sel]`.

Parameters:
- DATA_W, 8, word width in bits; legal range 2..256.
- SEL_W, 2, destination/select width; the downstream demux has 2**SEL_W outputs.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream word available
- in_ready  output  1  block can accept a word this cycle
- in_dest  input  SEL_W  destination channel of the offered word
- in_data  input  DATA_W  word to serialise
- a  output  1  serial data bit to the demux
- sel  output  SEL_W  channel select to the demux
- a_valid  output  1  `a` carries a live data bit this cycle
- done  output  1  one-cycle pulse on the last bit of a word

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset values: a=0, sel=0, a_valid=0, done=0, state=IDLE, bit counter=0, shift register=0. in_ready=0 while rst=1.
- States:
  - IDLE: in_ready=1, a=0, a_valid=0, sel holds its last value (0 after reset).
  - SHIFT: a_valid=1, a=shreg[0], sel=latched dest.
- Accept rule: a transfer occurs when in_valid & in_ready on a rising edge. Latch in_data into shreg and in_dest into the sel register, clear the counter, go to SHIFT.
- Latency: first bit appears on `a` the cycle after acceptance. A word occupies exactly DATA_W consecutive SHIFT cycles.
- SHIFT cycle action: each cycle, shreg shifts right by one and the counter increments.
- Last bit (counter==DATA_W-1):
  - done=1 and in_ready=1.
  - If a word is accepted this cycle, reload shreg/sel, clear the counter and stay in SHIFT. This gives back-to-back words with zero bubble.
  - If no word is accepted, go to IDLE.
- in_ready is 0 in SHIFT except on the last-bit cycle.
- Counter width is $clog2(DATA_W). It wraps only via explicit clear, never by overflow.
- sel stability: sel may change only on a cycle boundary where a new word is accepted. It never changes mid-word.
- in_dest/in_data are sampled only at acceptance. Changes while in_ready=0 have no effect.
- Reset mid-word: the word in flight is abandoned, outputs return to reset values the next cycle, and no done pulse is generated.
- in_valid held high with no word completing: no second accept until the last-bit cycle.

Decomposition:
- Shared package `demux_pkg`:
  - state enum {IDLE, SHIFT}
  - localparams DEMUX_SEL_W=2 and DEMUX_OUTS=4
  - function for counter width
- Sub-module: none required. A single module with one FSM, counter and shift register. The optional reuse candidate is `piso_shreg` (parallel-in serial-out register with load/shift).

Test Plan:
1. Reset, then idle 3 cycles -> a=0, sel=0, a_valid=0, done=0, in_ready=1 after rst deasserts.
2. Accept data=8'hA5, dest=2 -> a over 8 cycles = 1,0,1,0,0,1,0,1; sel=2 throughout; a_valid=1 ×8; done=1 on the 8th bit only; then IDLE. Demux y[2] shows the pattern, y[0/1/3]=0.
3. Back-to-back: in_valid held with 8'hFF/dest=1, then 8'h00/dest=3 presented on the last-bit cycle -> 16 contiguous a_valid cycles. sel switches 1→3 exactly at the word boundary; two done pulses 8 cycles apart.
4. Backpressure: change in_data/in_dest mid-word while in_valid=1 -> in_ready=0, and the in-flight bits and sel are unaffected.
5. Reset at bit 4 of word 8'h3C/dest=1 -> next cycle a=0, a_valid=0, sel=0, in_ready=0 until rst falls. No done pulse is produced.
6. DATA_W=2 build: data=2'b10, dest=0 -> a=0 then 1; done on the 2nd cycle; a back-to-back word is accepted on that cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the demux bit driver: FSM states, demux geometry
// and the bit-counter width helper.
package demux_pkg;

    localparam int DEMUX_SEL_W = 2;
    localparam int DEMUX_OUTS  = 1 << DEMUX_SEL_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must reach DATA_W-1; at least one bit even for tiny words.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_bit_driver_piso_shreg.sv
// Parallel-in serial-out shift register; load has priority over shift,
// bits leave LSB first on dout.
module piso_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] shreg_reg;

    // Load a new word or shift the current one right by one bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_reg <= '0;
        end else if (load) begin
            shreg_reg <= din;
        end else if (shift) begin
            shreg_reg <= {1'b0, shreg_reg[W-1:1]};
        end
    end

    assign dout = shreg_reg[0];

endmodule

// File: rtl/demux_bit_driver.sv
// Serialises destination-tagged words LSB-first onto a, holding sel at the
// destination for the whole word. A new word may be accepted on the last-bit
// cycle so consecutive words stream with no bubble.
module demux_bit_driver
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEL_W  = DEMUX_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_dest,
    input  logic [DATA_W-1:0] in_data,
    output logic              a,
    output logic [SEL_W-1:0]  sel,
    output logic              a_valid,
    output logic              done
);

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             last_bit;
    logic             accept;
    logic             shreg_bit;

    assign last_bit = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);
    // Reset is folded in so nothing upstream sees ready while held in reset.
    assign in_ready = !rst && ((state_reg == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;

    piso_shreg #(
        .W (DATA_W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state_reg == SHIFT),
        .din   (in_data),
        .dout  (shreg_bit)
    );

    // Next-state logic: accept reloads everything, otherwise count bits
    // and fall back to IDLE after the last one.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        if (accept) begin
            state_next = SHIFT;
            cnt_next   = '0;
            sel_next   = in_dest;
        end else if (state_reg == SHIFT) begin
            if (last_bit) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // State, counter and select registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
        end
    end

    assign a_valid = (state_reg == SHIFT);
    assign a       = a_valid && shreg_bit;
    assign sel     = sel_reg;
    assign done    = last_bit;

endmodule

// File: tb/tb_demux_bit_driver.sv
// Directed bench for demux_bit_driver: an 8-bit instance with a behavioural
// 1-to-4 demux on its outputs, and a 2-bit instance for the short-word case.
module tb_demux_bit_driver;

    logic clk = 1'b0;
    logic rst;

    // 8-bit instance
    logic       v8, rdy8, a8, av8, done8;
    logic [1:0] dest8, sel8;
    logic [7:0] d8;
    logic [3:0] y8;

    // 2-bit instance
    logic       v2, rdy2, a2, av2, done2;
    logic [1:0] dest2, sel2;
    logic [1:0] d2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    demux_bit_driver #(.DATA_W(8), .SEL_W(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_dest(dest8),
        .in_data(d8), .a(a8), .sel(sel8), .a_valid(av8), .done(done8)
    );

    demux_bit_driver #(.DATA_W(2), .SEL_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_dest(dest2),
        .in_data(d2), .a(a2), .sel(sel2), .a_valid(av2), .done(done2)
    );

    // Downstream 1-to-4 demux model.
    for (genvar gi = 0; gi < 4; gi++) begin : g_demux
        assign y8[gi] = (sel8 == 2'(gi)) ? a8 : 1'b0;
    end

    typedef struct {
        logic [7:0] data;
        logic [1:0] dest;
        logic [7:0] seq;   // seq[i] = expected a on the i-th bit cycle
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic out8(input string tag, input bit ea, input int esel,
                        input bit eav, input bit edone, input bit erdy);
        logic [3:0] y_exp;
        y_exp = eav ? (4'(ea) << esel) : 4'h0;
        chk({tag, " a"},       32'(a8),    32'(ea));
        chk({tag, " sel"},     32'(sel8),  32'(esel));
        chk({tag, " a_valid"}, 32'(av8),   32'(eav));
        chk({tag, " done"},    32'(done8), 32'(edone));
        chk({tag, " ready"},   32'(rdy8),  32'(erdy));
        chk({tag, " y"},       32'(y8),    32'(y_exp));
    endtask

    task automatic out2(input string tag, input bit ea, input int esel,
                        input bit eav, input bit edone, input bit erdy);
        chk({tag, " a2"},       32'(a2),    32'(ea));
        chk({tag, " sel2"},     32'(sel2),  32'(esel));
        chk({tag, " a_valid2"}, 32'(av2),   32'(eav));
        chk({tag, " done2"},    32'(done2), 32'(edone));
        chk({tag, " ready2"},   32'(rdy2),  32'(erdy));
    endtask

    // Send one word from IDLE and check all eight bit cycles plus the idle after.
    task automatic word8(input vec_t v);
        v8 = 1'b1; d8 = v.data; dest8 = v.dest;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) v8 = 1'b0;
            out8("word bit", v.seq[i], v.dest, 1'b1, i == 7, i == 7);
        end
        @(negedge clk);
        out8("word idle", 1'b0, v.dest, 1'b0, 1'b0, 1'b1);
        $display("[TB] word %02h -> dest %0d", v.data, v.dest);
    endtask

    initial begin
        vec_t       vecs[4];
        logic [7:0] e;

        vecs[0] = '{data: 8'hA5, dest: 2'd2, seq: 8'b1010_0101};
        vecs[1] = '{data: 8'h3C, dest: 2'd1, seq: 8'b0011_1100};
        vecs[2] = '{data: 8'h81, dest: 2'd3, seq: 8'b1000_0001};
        vecs[3] = '{data: 8'h6E, dest: 2'd0, seq: 8'b0110_1110};

        rst = 1'b1;
        v8 = 1'b0; d8 = '0; dest8 = '0;
        v2 = 1'b0; d2 = '0; dest2 = '0;

        // Reset state
        repeat (2) begin
            @(negedge clk);
            out8("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
            out2("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            out8("idle", 1'b0, 0, 1'b0, 1'b0, 1'b1);
        end
        $display("[TB] reset and idle checked");

        // Single words from the table
        for (int k = 0; k < 4; k++) word8(vecs[k]);

        // Back-to-back: FF to dest 1, then 00 to dest 3 offered on the last bit
        v8 = 1'b1; d8 = 8'hFF; dest8 = 2'd1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            out8("b2b first", 1'b1, 1, 1'b1, i == 7, i == 7);
            if (i == 7) begin d8 = 8'h00; dest8 = 2'd3; end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) v8 = 1'b0;
            out8("b2b second", 1'b0, 3, 1'b1, i == 7, i == 7);
        end
        @(negedge clk);
        out8("b2b idle", 1'b0, 3, 1'b0, 1'b0, 1'b1);
        $display("[TB] back-to-back FF->1, 00->3");

        // Backpressure: scramble data/dest mid-word with valid held high
        e = 8'h5A;
        v8 = 1'b1; d8 = e; dest8 = 2'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            out8("bp bit", e[i], 2, 1'b1, i == 7, i == 7);
            if (i < 7) begin
                d8 = 8'($urandom);
                dest8 = 2'(i);
            end else begin
                v8 = 1'b0;
            end
        end
        @(negedge clk);
        out8("bp idle", 1'b0, 2, 1'b0, 1'b0, 1'b1);
        $display("[TB] backpressure word 5A -> dest 2");

        // Reset while bit 4 of 3C is on the line
        e = 8'h3C;
        v8 = 1'b1; d8 = e; dest8 = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) v8 = 1'b0;
            out8("prerst bit", e[i], 1, 1'b1, 1'b0, 1'b0);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            out8("midrst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            out8("postrst", 1'b0, 0, 1'b0, 1'b0, 1'b1);
        end
        $display("[TB] reset mid-word 3C -> dest 1");

        // 2-bit build: 2'b10 to dest 0, then 2'b01 to dest 3 back-to-back
        v2 = 1'b1; d2 = 2'b10; dest2 = 2'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out2("w2 first", i == 1, 0, 1'b1, i == 1, i == 1);
            if (i == 1) begin d2 = 2'b01; dest2 = 2'd3; end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) v2 = 1'b0;
            out2("w2 second", i == 0, 3, 1'b1, i == 1, i == 1);
        end
        @(negedge clk);
        out2("w2 idle", 1'b0, 3, 1'b0, 1'b0, 1'b1);
        $display("[TB] DATA_W=2 words 10->0, 01->3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
